// File: rtl/pipe_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
// Shared constants for the pipeline stall controller: StallBus layout and
// stall codes, stall source codes, FSM state encodings and small helpers that
// map the raw stage requests onto the winning source and its StallBus value.
// Optional feature macro used by the top: PIPE_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

  // Widths
  localparam int unsigned STALL_W = 6;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned PERF_W  = 32;

  // StallBus bit positions (one flag per pipeline register)
  localparam int unsigned BIT_PC  = 0;
  localparam int unsigned BIT_IF  = 1;
  localparam int unsigned BIT_ID  = 2;
  localparam int unsigned BIT_EX  = 3;
  localparam int unsigned BIT_MEM = 4;
  localparam int unsigned BIT_WB  = 5;

  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef logic [SRC_W-1:0]   stall_src_t;
  typedef logic [STATE_W-1:0] state_t;

  // Request bundle from the three stages able to stall the pipe
  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
  } stall_req_t;

  // Per-bit stall levels and the level of rst that resets the block
  localparam logic STOP       = 1'b1;
  localparam logic NOSTOP     = 1'b0;
  localparam logic RST_ENABLE = 1'b0;

  // Stall codes: the requesting stage and everything upstream of it hold
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  // Stall source codes
  localparam stall_src_t SRC_NONE = 2'd0;
  localparam stall_src_t SRC_ID   = 2'd1;
  localparam stall_src_t SRC_EX   = 2'd2;
  localparam stall_src_t SRC_MEM  = 2'd3;

  // FSM state encodings
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd0;
  localparam logic [STATE_W-1:0] ST_HOLD    = 2'd1;
  localparam logic [STATE_W-1:0] ST_TIMEOUT = 2'd2;

  // Fixed priority MEM > EX > ID: the deepest stalled stage wins
  function automatic stall_src_t pick_src(input stall_req_t req);
    stall_src_t src;
    src = SRC_NONE;
    if (req.mem) begin
      src = SRC_MEM;
    end else if (req.ex) begin
      src = SRC_EX;
    end else if (req.id) begin
      src = SRC_ID;
    end
    return src;
  endfunction

  // StallBus value for a given winning source
  function automatic stall_bus_t src_to_stall(input stall_src_t src);
    stall_bus_t code;
    code = STALL_NONE;
    case (src)
      SRC_ID:  code = STALL_ID;
      SRC_EX:  code = STALL_EX;
      SRC_MEM: code = STALL_MEM;
      default: code = STALL_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_sat_counter
// Saturating up-counter with synchronous clear. Asserting clr and inc in the
// same cycle restarts the count at one, which lets the owner open a new
// episode and count its first cycle in a single step.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   clr    in   restart the count from zero
//   inc    in   advance the count by one, saturating at all-ones
//   cnt    out  registered count, CNT_W bits
// -----------------------------------------------------------------------------
module pipe_stall_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] base;

  // Next count: optional restart, then optional saturating increment
  always_comb begin
    cnt_d = cnt_q;
    base  = clr ? '0 : cnt_q;
    if (inc) begin
      cnt_d = (base == CNT_MAX) ? base : base + CNT_W'(1);
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Pipeline stall controller. Combines the ID/EX/MEM stall requests into the
// StallBus seen by every pipeline register, tracks stall episodes in a small
// FSM with a consecutive-stall watchdog, and records the most recent stall
// source and episode length for debug.
//
// Optional feature: define PIPE_PERF_CNT_EN to build the two 32-bit wrapping
// performance counters; otherwise both perf ports read constant zero.
//
// Ports:
//   clk                in   pipeline clock
//   rst                in   asynchronous active-low reset
//   stallreq_id        in   ID stage stall request (load-use)
//   stallreq_ex        in   EX stage stall request (multi-cycle op)
//   stallreq_mem       in   MEM stage stall request (memory wait)
//   stall[5:0]         out  StallBus, combinational (PC,IF,ID,EX,MEM,WB)
//   stall_src[1:0]     out  source of the current/last stall (0 none,1 ID,2 EX,3 MEM)
//   stall_len[CNT_W]   out  length of current/last stall episode, saturating
//   stall_timeout      out  sticky watchdog flag
//   perf_stall_cycles  out  stalled cycle count (optional)
//   perf_bubbles       out  bubbles injected into EX (optional)
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_id,
  input  logic                 stallreq_ex,
  input  logic                 stallreq_mem,
  output logic [STALL_W-1:0]   stall,
  output logic [SRC_W-1:0]     stall_src,
  output logic [CNT_W-1:0]     stall_len,
  output logic                 stall_timeout,
  output logic [PERF_W-1:0]    perf_stall_cycles,
  output logic [PERF_W-1:0]    perf_bubbles
);

  // Length at which a still-present request trips the watchdog
  localparam logic [CNT_W-1:0] TRIP_LEN = CNT_W'(STALL_TIMEOUT - 1);

  stall_req_t req;
  stall_src_t win_src;
  logic       req_any;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  stall_src_t         stall_src_q;
  stall_src_t         stall_src_d;
  logic               stall_timeout_q;
  logic               stall_timeout_d;
  logic               len_clr;
  logic               len_inc;

  assign req     = '{mem: stallreq_mem, ex: stallreq_ex, id: stallreq_id};
  assign win_src = pick_src(req);
  assign req_any = stallreq_id | stallreq_ex | stallreq_mem;

  // StallBus follows requests in the same cycle; forced idle while in reset
  assign stall = (rst == RST_ENABLE) ? STALL_NONE : src_to_stall(win_src);

  // Episode FSM: next state, source capture, length control, watchdog
  always_comb begin
    state_d         = state_q;
    stall_src_d     = stall_src_q;
    stall_timeout_d = stall_timeout_q;
    len_clr         = 1'b0;
    len_inc         = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req_any) begin
          state_d     = ST_HOLD;
          stall_src_d = win_src;
          len_clr     = 1'b1;
          len_inc     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (req_any) begin
          stall_src_d = win_src;
          len_inc     = 1'b1;
          if (stall_len == TRIP_LEN) begin
            state_d         = ST_TIMEOUT;
            stall_timeout_d = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_TIMEOUT: begin
        if (req_any) begin
          stall_src_d = win_src;
          len_inc     = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q         <= ST_RUN;
      stall_src_q     <= SRC_NONE;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_src_q     <= stall_src_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // Episode length; holds its last value between episodes
  pipe_stall_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_len_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (len_clr),
    .inc   (len_inc),
    .cnt   (stall_len)
  );

  assign stall_src     = stall_src_q;
  assign stall_timeout = stall_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_cycles_q;
  logic [PERF_W-1:0] perf_stall_cycles_d;
  logic [PERF_W-1:0] perf_bubbles_q;
  logic [PERF_W-1:0] perf_bubbles_d;

  // A bubble enters EX when ID holds while EX drains
  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q;
    perf_bubbles_d      = perf_bubbles_q;
    if (stall[BIT_PC] == STOP) begin
      perf_stall_cycles_d = perf_stall_cycles_q + PERF_W'(1);
    end
    if ((stall[BIT_ID] == STOP) && (stall[BIT_EX] == NOSTOP)) begin
      perf_bubbles_d = perf_bubbles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      perf_stall_cycles_q <= '0;
      perf_bubbles_q      <= '0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_bubbles_q      <= perf_bubbles_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_bubbles      = perf_bubbles_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_bubbles      = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Self-checking bench: directed scenarios with literal expectations followed
// by randomized request traffic, all compared every cycle against a
// behavioural model of episode length, source, watchdog and perf counts.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int unsigned T_TO  = 4;
  localparam int unsigned T_CW  = 3;
  localparam int unsigned T_MAX = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sid = 1'b0;
  logic        sex = 1'b0;
  logic        smem = 1'b0;
  logic [5:0]  stall;
  logic [1:0]  stall_src;
  logic [T_CW-1:0] stall_len;
  logic        stall_timeout;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_bubbles;

  pipe_stall_ctrl #(
    .STALL_TIMEOUT (T_TO),
    .CNT_W         (T_CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_id       (sid),
    .stallreq_ex       (sex),
    .stallreq_mem      (smem),
    .stall             (stall),
    .stall_src         (stall_src),
    .stall_len         (stall_len),
    .stall_timeout     (stall_timeout),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_bubbles      (perf_bubbles)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_run    = 0;     // cycles in the current/last episode, unbounded
  logic        m_prev   = 1'b0;  // previous clocked cycle had a request
  logic [1:0]  m_src    = 2'd0;
  logic        m_to     = 1'b0;
  logic [31:0] m_pstall = 32'd0;
  logic [31:0] m_pbub   = 32'd0;

  function automatic logic [5:0] m_stall(input logic r, input logic id, input logic ex, input logic mem);
    if (!r)       return 6'b000000;
    if (mem)      return 6'b011111;
    if (ex)       return 6'b001111;
    if (id)       return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic logic [1:0] m_winner(input logic id, input logic ex, input logic mem);
    if (mem) return 2'd3;
    if (ex)  return 2'd2;
    if (id)  return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_len();
    return (m_run > int'(T_MAX)) ? 32'(T_MAX) : 32'(m_run);
  endfunction

  // Compare process: combinational StallBus mid-low-phase, registers after edge
  initial begin
    logic req;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        m_run = 0; m_prev = 1'b0; m_src = 2'd0; m_to = 1'b0;
        m_pstall = 32'd0; m_pbub = 32'd0;
      end
      chk("stall", 32'(stall), 32'(m_stall(rst, sid, sex, smem)));
      @(posedge clk);
      if (rst) begin
        req = sid | sex | smem;
        if (req) begin
          m_run = m_prev ? m_run + 1 : 1;
          m_src = m_winner(sid, sex, smem);
          if (m_run >= int'(T_TO)) m_to = 1'b1;
          m_pstall = m_pstall + 32'd1;
          if (sid && !sex && !smem) m_pbub = m_pbub + 32'd1;
        end
        m_prev = req;
      end
      #1;
      chk("stall_src", 32'(stall_src), 32'(m_src));
      chk("stall_len", 32'(stall_len), m_len());
      chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef PIPE_PERF_CNT_EN
      chk("perf_stall_cycles", perf_stall_cycles, m_pstall);
      chk("perf_bubbles", perf_bubbles, m_pbub);
`else
      chk("perf_stall_cycles", perf_stall_cycles, 32'd0);
      chk("perf_bubbles", perf_bubbles, 32'd0);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic id, input logic ex, input logic mem);
    @(negedge clk);
    rst = r; sid = id; sex = ex; smem = mem;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] pat;
    // Reset held with every request raised: bus idle, state cleared
    rst = 1'b0; sid = 1'b1; sex = 1'b1; smem = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    #3;
    chk("lit_rst_stall", 32'(stall), 32'h00);
    chk("lit_rst_timeout", 32'(stall_timeout), 32'd0);
    chk("lit_rst_len", 32'(stall_len), 32'd0);
    chk("lit_rst_src", 32'(stall_src), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #3;
    chk("lit_release_stall", 32'(stall), 32'h1F);
    do_reset();

    // Single-cycle ID request, then a fresh episode proves return to RUN
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    chk("lit_id_pulse_stall", 32'(stall), 32'h07);
    after_edge();
    chk("lit_id_pulse_src", 32'(stall_src), 32'd1);
    chk("lit_id_pulse_len", 32'(stall_len), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("lit_id_hold_len", 32'(stall_len), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    after_edge();
    chk("lit_new_episode_len", 32'(stall_len), 32'd1);
    chk("lit_new_episode_src", 32'(stall_src), 32'd3);

    // EX and ID together for three cycles: EX wins, no bubbles
    do_reset();
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      #3;
      chk("lit_exid_stall", 32'(stall), 32'h0F);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("lit_exid_len", 32'(stall_len), 32'd3);
    chk("lit_exid_src", 32'(stall_src), 32'd2);
    chk("lit_exid_bubbles", perf_bubbles, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("lit_exid_pstall", perf_stall_cycles, 32'd3);
`else
    chk("lit_exid_pstall", perf_stall_cycles, 32'd0);
`endif

    // EX then MEM without a gap: one episode of four cycles
    do_reset();
    repeat (2) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      #3;
      chk("lit_exmem_stall_ex", 32'(stall), 32'h0F);
    end
    repeat (2) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      #3;
      chk("lit_exmem_stall_mem", 32'(stall), 32'h1F);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("lit_exmem_len", 32'(stall_len), 32'd4);
    chk("lit_exmem_src", 32'(stall_src), 32'd3);
    chk("lit_exmem_timeout", 32'(stall_timeout), 32'd1);

    // Long MEM stall: watchdog after the 4th cycle, length saturates at 7
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      #3;
      chk("lit_long_stall", 32'(stall), 32'h1F);
      after_edge();
      chk("lit_long_timeout", 32'(stall_timeout), (i >= 4) ? 32'd1 : 32'd0);
      chk("lit_long_len", 32'(stall_len), (i >= 7) ? 32'd7 : 32'(i));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("lit_sticky_timeout", 32'(stall_timeout), 32'd1);
    // Reset mid-episode clears everything at once
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    chk("lit_midrst_stall", 32'(stall), 32'h00);
    chk("lit_midrst_timeout", 32'(stall_timeout), 32'd0);
    chk("lit_midrst_len", 32'(stall_len), 32'd0);

    // ID held five cycles: five bubbles into EX
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
`ifdef PIPE_PERF_CNT_EN
    chk("lit_bub_bubbles", perf_bubbles, 32'd5);
    chk("lit_bub_pstall", perf_stall_cycles, 32'd5);
`else
    chk("lit_bub_bubbles", perf_bubbles, 32'd0);
    chk("lit_bub_pstall", perf_stall_cycles, 32'd0);
`endif

    // Randomized traffic with bursty requests and occasional resets
    pat = 3'b000;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        pat = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) pat = 3'b000;
      end
      if ($urandom_range(0, 79) == 0) begin
        drive(1'b0, pat[0], pat[1], pat[2]);
      end else begin
        drive(1'b1, pat[0], pat[1], pat[2]);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
